// File: rtl/multi_pwm_sync.sv
// Multi-channel PWM generator sharing one period counter. Duty, period, prescaler and mode
// are double-buffered and move into the active set at the period boundary or on ForceUpdate.
module multi_pwm_sync #(
  parameter int unsigned NB_PWM      = 8,
  parameter int unsigned RESOLUTION  = 8,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter int unsigned ADDR_W      = 4,
  localparam int unsigned DATA_W = (RESOLUTION > PRESC_WIDTH) ? RESOLUTION : PRESC_WIDTH
) (
  input  logic              ClkIn,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              ForceUpdate,
  input  logic [NB_PWM-1:0] oe,
  input  logic [NB_PWM-1:0] Pol,
  output logic [NB_PWM-1:0] PWMout,
  output logic              PeriodEnd
);

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [RESOLUTION-1:0]  r_ton_s [NB_PWM];
  logic [RESOLUTION-1:0]  r_ton_a [NB_PWM];
  logic [RESOLUTION-1:0]  r_per_s, r_per_a;
  logic [PRESC_WIDTH-1:0] r_presc_s, r_presc_a;
  logic                   r_mode_s, r_mode_a;
  logic [RESOLUTION-1:0]  r_cnt;
  logic [PRESC_WIDTH-1:0] r_pre;
  dir_e                   r_dir;
  logic [NB_PWM-1:0]      r_pwm;
  logic                   r_pend;

  logic                   w_tick, w_bnd, w_load;
  logic [RESOLUTION-1:0]  w_cnt_d;
  logic [PRESC_WIDTH-1:0] w_pre_d;
  dir_e                   w_dir_d;
  logic [NB_PWM-1:0]      w_pwm_d;

  always_comb begin
    w_tick  = (r_pre == r_presc_a);
    w_bnd   = 1'b0;
    w_cnt_d = r_cnt;
    w_dir_d = r_dir;
    w_pre_d = w_tick ? '0 : r_pre + PRESC_WIDTH'(1);
    if (w_tick) begin
      if (!r_mode_a) begin
        if (r_cnt == r_per_a) w_bnd = 1'b1;
        else                  w_cnt_d = r_cnt + RESOLUTION'(1);
      end else if (r_per_a == '0) begin
        w_bnd = 1'b1;
      end else if (r_dir == DirUp) begin
        if (r_cnt == r_per_a) begin
          // With a period of 1 the turn-around step already lands on 0.
          if (r_per_a == RESOLUTION'(1)) begin
            w_bnd = 1'b1;
          end else begin
            w_cnt_d = r_cnt - RESOLUTION'(1);
            w_dir_d = DirDown;
          end
        end else begin
          w_cnt_d = r_cnt + RESOLUTION'(1);
        end
      end else begin
        if (r_cnt == RESOLUTION'(1)) w_bnd = 1'b1;
        else                         w_cnt_d = r_cnt - RESOLUTION'(1);
      end
    end
    w_load = w_bnd | ForceUpdate;
    if (w_load) begin
      w_cnt_d = '0;
      w_dir_d = DirUp;
      w_pre_d = '0;
    end
  end

  always_comb begin
    w_pwm_d = '0;
    for (int i = 0; i < NB_PWM; i++) begin
      w_pwm_d[i] = oe[i] ? ((r_cnt < r_ton_a[i]) ^ Pol[i]) : Pol[i];
    end
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      r_ton_s   <= '{default: '0};
      r_ton_a   <= '{default: '0};
      r_per_s   <= '1;
      r_per_a   <= '1;
      r_presc_s <= '0;
      r_presc_a <= '0;
      r_mode_s  <= 1'b0;
      r_mode_a  <= 1'b0;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_dir     <= DirUp;
      r_pwm     <= '0;
      r_pend    <= 1'b0;
    end else begin
      // Non-blocking order means a write on the load edge moves the old shadow value.
      if (WrEn) begin
        for (int i = 0; i < NB_PWM; i++) begin
          if (WrAddr == ADDR_W'(i)) r_ton_s[i] <= WrData[RESOLUTION-1:0];
        end
        if (WrAddr == ADDR_W'(NB_PWM))     r_per_s   <= WrData[RESOLUTION-1:0];
        if (WrAddr == ADDR_W'(NB_PWM + 1)) r_presc_s <= WrData[PRESC_WIDTH-1:0];
        if (WrAddr == ADDR_W'(NB_PWM + 2)) r_mode_s  <= WrData[0];
      end
      if (w_load) begin
        r_ton_a   <= r_ton_s;
        r_per_a   <= r_per_s;
        r_presc_a <= r_presc_s;
        r_mode_a  <= r_mode_s;
      end
      r_cnt  <= w_cnt_d;
      r_pre  <= w_pre_d;
      r_dir  <= w_dir_d;
      r_pwm  <= w_pwm_d;
      r_pend <= w_load;
    end
  end

  assign PWMout    = r_pwm;
  assign PeriodEnd = r_pend;

endmodule

// File: doc/multi_pwm_sync.md
Name: multi_pwm_sync

Overview:
Multi-channel PWM generator on one system clock, sharing a single period counter across NB_PWM channels. Each channel has its own duty-cycle compare register, polarity and output enable. All configuration (duty, period, prescaler, mode) is double-buffered and applied atomically at the period boundary. Supports edge-aligned and center-aligned modes and feeds motor/LED drivers from the HAL register interface.

Parameters:
NB_PWM, 8, number of PWM channels
RESOLUTION, 8, width of counter, period and duty registers
PRESC_WIDTH, 8, width of clock prescaler
ADDR_W, 4, width of WrAddr; must satisfy 2^ADDR_W >= NB_PWM+3

Ports:
ClkIn  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
WrEn  input  1  write strobe, one write per cycle
WrAddr  input  ADDR_W  0..NB_PWM-1 = Ton[ch]; NB_PWM = Period; NB_PWM+1 = Prescale; NB_PWM+2 = Mode (bit0: 0 edge, 1 center)
WrData  input  max(RESOLUTION,PRESC_WIDTH)  write data, LSBs used
ForceUpdate  input  1  immediate shadow-to-active copy and counter restart
oe  input  NB_PWM  per-channel output enable
Pol  input  NB_PWM  per-channel polarity (1 = inverted)
PWMout  output  NB_PWM  registered PWM outputs
PeriodEnd  output  1  one-cycle pulse, new active config in effect

Behaviour:
- Reset: all shadow/active Ton = 0, Period = 2^RESOLUTION-1, Prescale = 0, Mode = edge; Cnt = 0, PreCnt = 0, Dir = up; PWMout = 0, PeriodEnd = 0. Reset dominates WrEn and ForceUpdate.
- Writes: WrEn loads the addressed shadow register only. Out-of-range address is ignored. Active values change only at a boundary or on ForceUpdate.
- Prescaler: PreCnt counts 0..PrescA and wraps. tick = (PreCnt == PrescA). PrescA = 0 gives a tick every cycle.
- Edge mode, on tick: Cnt == PerA -> Cnt = 0 (boundary); else Cnt + 1. Period = PerA+1 ticks.
- Center mode, on tick:
  - Dir up: Cnt == PerA -> Cnt - 1, Dir = down; else Cnt + 1.
  - Dir down: Cnt - 1; Cnt == 1 -> Dir = up (boundary).
  - PerA = 0: Cnt stays 0, boundary every tick.
  - Period = 2*PerA ticks. Sequence for P = 2: 0,1,2,1,0,1,...
- Boundary, same edge as the Cnt update:
  - copy shadow Ton[], Period, Prescale, Mode to active;
  - Cnt = 0, Dir = up, PreCnt = 0;
  - PeriodEnd = 1 for the next cycle only.
- Write coinciding with boundary: the old shadow value transfers; the new value lands in shadow and applies at the next boundary.
- ForceUpdate: same actions as a boundary, regardless of tick. Also pulses PeriodEnd. Simultaneous WrEn follows the same old-value rule.
- Compare: raw[i] = (Cnt < TonA[i]), unsigned, RESOLUTION bits.
  - TonA = 0 -> always low.
  - TonA > PerA -> always high (100%).
  - Edge mode: high for the first TonA ticks of the period.
  - Center mode: pulse is symmetric about Cnt = 0.
- Output: PWMout[i] <= oe[i] ? (raw[i] ^ Pol[i]) : Pol[i]. Disabled channels drive their inactive level. Registered, one ClkIn of latency from Cnt. oe and Pol are not buffered and act on the next edge.
- Mode change mid-period takes effect at the boundary only. Dir is forced up when entering a period.
- Reset mid-period: next cycle is the exact reset state; shadow contents are lost.

Test Plan:
- Reset, then Period=9, Prescale=0, Ton[0]=3, ForceUpdate -> PWMout[0] high 3 of every 10 cycles; PeriodEnd pulses every 10 cycles.
- Ton[1]=0 and Ton[2]=12 with Period=9 -> PWMout[1] constantly 0, PWMout[2] constantly 1; Pol[2]=1 -> constantly 0; oe[2]=0 -> constantly Pol[2].
- Prescale=3, Period=4, Ton=2 -> period 20 clocks, high 8 clocks; Cnt holds 4 clocks per value.
- Center mode, Period=4, Ton=1 -> Cnt 0,1,2,3,4,3,2,1 repeating; output high only at Cnt=0, i.e. 1 tick per 8-tick period.
- Write Ton[0]=7 mid-period, then again exactly on the boundary cycle -> old duty until boundary; first value applies one period later, second value the period after.
- Assert Reset during a high pulse with shadow writes pending -> PWMout = 0 and PeriodEnd = 0 next cycle; Period reads 255 behaviour (256-cycle period) until reconfigured.
